// File: rtl/inst_loader.sv
// Byte-stream program loader: parses a count-prefixed frame, writes big-endian words to
// instruction memory from address 0, verifies an XOR checksum and then releases the core.
module inst_loader #(
    parameter int unsigned INST_DEPTH = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        StCntHi,
        StCntLo,
        StData,
        StCsum,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           count_q, count_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;

    logic        accept;
    logic [15:0] full_count;

    assign byte_ready = (state_q == StCntHi) || (state_q == StCntLo) ||
                        (state_q == StData)  || (state_q == StCsum);
    assign accept     = byte_valid && byte_ready;
    assign full_count = {cnt_hi_q, byte_data};

    always_comb begin
        state_d  = state_q;
        cnt_hi_d = cnt_hi_q;
        count_d  = count_q;
        idx_d    = idx_q;
        word_d   = word_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        words_d  = words_q;

        unique case (state_q)
            StCntHi: begin
                if (accept) begin
                    cnt_hi_d = byte_data;
                    state_d  = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    count_d = full_count;
                    if (32'(full_count) > INST_DEPTH) begin
                        state_d = StError;
                    end else if (full_count == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    word_d = {word_q[15:0], byte_data};
                    csum_d = csum_q ^ byte_data;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Write address is the count of words already written.
                        we_d    = 1'b1;
                        wdata_d = {word_q, byte_data};
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        words_d = words_q + 1'b1;
                        if (32'(words_q) + 32'd1 == 32'(count_q)) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (byte_data == csum_q) ? StDone : StError;
                end
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StCntHi;
            cnt_hi_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            csum_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            words_q  <= words_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = words_q;
    assign load_done    = (state_q == StDone);
    assign load_error   = (state_q == StError);
    assign cpu_run      = (state_q == StDone);

endmodule
